// File: rtl/snake_grid_reader.sv
// Sweeps the game-grid memory in row-major order, one outstanding read at a time,
// and streams each (x, y, code) cell on a valid/ready port while tallying snake and food cells.
module snake_grid_reader #(
  parameter int GRID_W  = 16,
  parameter int GRID_H  = 16,
  parameter int COORD_W = 4,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               rd_en,
  output logic [COORD_W-1:0] x_loc,
  output logic [COORD_W-1:0] y_loc,
  input  logic [1:0]         rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic [1:0]         out_code,
  output logic               done,
  output logic [8:0]         snake_count,
  output logic [8:0]         food_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(GRID_H - 1);

  localparam logic [1:0] CODE_FOOD  = 2'b01;
  localparam logic [1:0] CODE_SNAKE = 2'b10;

  state_t           state, state_next;
  logic [LAT_W-1:0] wait_cnt;
  logic             wait_last;
  logic             last_col;
  logic             last_cell;
  logic             handshake;

  assign wait_last = (wait_cnt == LAT_LAST);
  assign last_col  = (x_loc == X_LAST);
  assign last_cell = last_col && (y_loc == Y_LAST);

  // Control outputs are pure decodes of the state, so reset forces them low directly.
  assign busy      = (state == ISSUE) || (state == WAIT) || (state == OUT);
  assign rd_en     = (state == ISSUE);
  assign out_valid = (state == OUT);
  assign done      = (state == DONE);
  assign handshake = out_valid && out_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_last) state_next = OUT;
      OUT:     if (handshake) state_next = last_cell ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_loc       <= '0;
      y_loc       <= '0;
      wait_cnt    <= '0;
      out_x       <= '0;
      out_y       <= '0;
      out_code    <= '0;
      snake_count <= '0;
      food_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            x_loc       <= '0;
            y_loc       <= '0;
            snake_count <= '0;
            food_count  <= '0;
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT: begin
          // Capture on the edge that closes the final latency cycle.
          if (wait_last) begin
            out_code <= rd_data;
            out_x    <= x_loc;
            out_y    <= y_loc;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        OUT: begin
          if (handshake) begin
            if (out_code == CODE_SNAKE) snake_count <= snake_count + 9'd1;
            if (out_code == CODE_FOOD)  food_count  <= food_count + 9'd1;
            // The final cell leaves the address parked at the last coordinate.
            if (!last_cell) begin
              if (last_col) begin
                x_loc <= '0;
                y_loc <= y_loc + 1'b1;
              end else begin
                x_loc <= x_loc + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_grid_reader.sv
// Self-checking bench for snake_grid_reader: a scenario table of full-grid scans,
// each compared beat by beat against a row-major walk of a behavioural grid memory.
module tb_snake_grid_reader;

  localparam int GRID_W  = 16;
  localparam int GRID_H  = 16;
  localparam int COORD_W = 4;
  localparam int MEM_LAT = 1;
  localparam int CELLS   = GRID_W * GRID_H;
  localparam int BOUND   = 6000;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               busy;
  logic               rd_en;
  logic [COORD_W-1:0] x_loc;
  logic [COORD_W-1:0] y_loc;
  logic [1:0]         rd_data;
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] out_x;
  logic [COORD_W-1:0] out_y;
  logic [1:0]         out_code;
  logic               done;
  logic [8:0]         snake_count;
  logic [8:0]         food_count;

  int checks   = 0;
  int failures = 0;

  logic [1:0] grid [GRID_H][GRID_W];
  logic [1:0] pipe [MEM_LAT];

  snake_grid_reader #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .COORD_W(COORD_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .rd_en(rd_en),
    .x_loc(x_loc), .y_loc(y_loc), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_code(out_code),
    .done(done), .snake_count(snake_count), .food_count(food_count)
  );

  always #5 clk = ~clk;

  // Grid memory: returns the addressed cell MEM_LAT cycles after rd_en, noise otherwise.
  always @(posedge clk) begin
    pipe[0] <= rd_en ? grid[y_loc][x_loc] : 2'($urandom);
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = pipe[MEM_LAT-1];

  typedef struct {
    int grid_mode;     // 0 empty, 1 snake/food pattern, 2 random, 3 all snake
    int stall_beat;    // beat index held with out_ready low, -1 none
    int stall_cycles;
    int restart_beat;  // beat index at which start is pulsed while busy, -1 none
    int reset_beat;    // beat index at which reset is pulsed, -1 none
    int rand_ready;
    int exp_done_cyc;  // -1 when not fixed
    int exp_snake;     // -1 means take from model
    int exp_food;
  } scen_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_grid(input int mode);
    for (int y = 0; y < GRID_H; y++)
      for (int x = 0; x < GRID_W; x++)
        case (mode)
          2:       grid[y][x] = 2'($urandom_range(0, 3));
          3:       grid[y][x] = 2'b10;
          default: grid[y][x] = 2'b00;
        endcase
    if (mode == 1) begin
      grid[2][3]  = 2'b10;
      grid[2][4]  = 2'b10;
      grid[0][15] = 2'b01;
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_xy"},    {x_loc, y_loc}, 0);
    check({tag, "_out"},   {out_x, out_y, out_code}, 0);
    check({tag, "_counts"}, {snake_count, food_count}, 0);
  endtask

  task automatic run_scan(input scen_t s);
    int beat = 0;
    int cyc = 0;
    int stall_rem = s.stall_cycles;
    int done_cyc = -1;
    int model_snake = 0;
    int model_food = 0;
    int exp_snake, exp_food;
    logic held = 1'b0;
    logic [COORD_W-1:0] hx, hy;
    logic [1:0] hc;
    logic rdy;

    for (int y = 0; y < GRID_H; y++)
      for (int x = 0; x < GRID_W; x++) begin
        if (grid[y][x] == 2'b10) model_snake++;
        if (grid[y][x] == 2'b01) model_food++;
      end
    exp_snake = (s.exp_snake < 0) ? model_snake : s.exp_snake;
    exp_food  = (s.exp_food  < 0) ? model_food  : s.exp_food;

    out_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);

    while (cyc < BOUND) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      rdy = s.rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (out_valid) begin
        if (!held) begin
          check("beat_x",    out_x,    (beat % GRID_W));
          check("beat_y",    out_y,    (beat / GRID_W));
          check("beat_code", out_code, grid[beat / GRID_W][beat % GRID_W]);
          hx = out_x; hy = out_y; hc = out_code;
        end else begin
          check("hold_beat", {out_x, out_y, out_code}, {hx, hy, hc});
          check("hold_no_rd", rd_en, 0);
        end
        if (beat == s.reset_beat) begin
          reset = 1'b1;
          @(negedge clk);
          check_idle_zero("mid_reset");
          reset = 1'b0;
          for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_quiet", {done, busy}, 0);
          end
          return;
        end
        if (beat == s.restart_beat && !held) start = 1'b1;
        if (beat == s.stall_beat && stall_rem > 0) begin
          stall_rem--;
          rdy = 1'b0;
        end
        if (rdy) begin
          beat++;
          held = 1'b0;
        end else begin
          held = 1'b1;
        end
      end
      out_ready = rdy;
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end

    if (done_cyc < 0) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("beat_total", beat, CELLS);
    check("done_busy_low", busy, 0);
    if (s.exp_done_cyc >= 0) check("done_latency", done_cyc, s.exp_done_cyc);
    check("snake_count", snake_count, exp_snake);
    check("food_count",  food_count,  exp_food);
    @(negedge clk);
    check("done_single", done, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_after_done", {done, busy, out_valid}, 0);
    end
    check("counts_hold", {snake_count, food_count}, {9'(exp_snake), 9'(exp_food)});
  endtask

  scen_t scen [8];

  initial begin
    scen[0] = '{0, -1, 0, -1,  -1, 0, 768,  0, 0};
    scen[1] = '{1, -1, 0, -1,  -1, 0, 768,  2, 1};
    scen[2] = '{1,  0, 5, -1,  -1, 0, 773,  2, 1};
    scen[3] = '{2, -1, 0, 10,  -1, 0, 768, -1, -1};
    scen[4] = '{2, -1, 0, -1, 100, 0,  -1, -1, -1};
    scen[5] = '{2, -1, 0, -1,  -1, 0, 768, -1, -1};
    scen[6] = '{3, -1, 0, -1,  -1, 0, 768, 256, 0};
    scen[7] = '{2, -1, 0, -1,  -1, 1,  -1, -1, -1};

    reset = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      fill_grid(scen[i].grid_mode);
      run_scan(scen[i]);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
